// File: rtl/traffic_test_sequencer.sv
// Sequences one traffic test over AXI4-Lite: mux setup, generator and
// analyzer programming, timed run, generator stop, drain, analyzer freeze.
module traffic_test_sequencer #(
    parameter logic [31:0] GEN_BASE     = 32'hA0170000,
    parameter logic [31:0] ANA_BASE     = 32'hA0180000,
    parameter logic [31:0] MUX_GEN_BASE = 32'hA0100000,
    parameter logic [31:0] MUX_ANA_BASE = 32'hA0150000,
    parameter int unsigned DRAIN_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] duration,
    input  logic [31:0] ifg,
    input  logic [31:0] frame_size,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  step
);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_RESP, RUN, DRAIN, DONE
    } state_t;

    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  step_nxt;
    logic        issue;
    logic [31:0] dur_q, ifg_q, fs_q, cnt;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs, bad, last_run;

    assign aw_hs    = m_axi_awvalid & m_axi_awready;
    assign w_hs     = m_axi_wvalid & m_axi_wready;
    assign bad      = m_axi_bresp != 2'b00;
    assign last_run = (dur_q <= 32'd1) || (cnt == dur_q - 32'd1);

    assign m_axi_awprot = 3'd0;
    assign m_axi_wstrb  = 4'hF;
    assign m_axi_bready = state == WR_RESP;
    assign busy         = state != IDLE;
    assign done         = state == DONE;

    // Write table: address/data for the current step (step 0 reads as zero).
    always_comb begin
        m_axi_awaddr = 32'd0;
        m_axi_wdata  = 32'd0;
        case (step)
            4'd1: begin m_axi_awaddr = MUX_GEN_BASE + 32'h08; m_axi_wdata = 32'd3; end
            4'd2: begin m_axi_awaddr = MUX_ANA_BASE + 32'h08; m_axi_wdata = 32'd0; end
            4'd3: begin m_axi_awaddr = GEN_BASE + 32'h14; m_axi_wdata = ifg_q; end
            4'd4: begin m_axi_awaddr = GEN_BASE + 32'h44; m_axi_wdata = fs_q; end
            4'd5: begin m_axi_awaddr = ANA_BASE + 32'h10; m_axi_wdata = 32'd1; end
            4'd6: begin m_axi_awaddr = GEN_BASE + 32'h10; m_axi_wdata = 32'd3; end
            4'd7: begin m_axi_awaddr = GEN_BASE + 32'h10; m_axi_wdata = 32'd0; end
            4'd8: begin m_axi_awaddr = ANA_BASE + 32'h10; m_axi_wdata = 32'd3; end
            default: begin m_axi_awaddr = 32'd0; m_axi_wdata = 32'd0; end
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, next step, and the pulse that launches a new write.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WR_ISSUE;
                    step_nxt  = 4'd1;
                    issue     = 1'b1;
                end
            end
            WR_ISSUE: begin
                if ((aw_done | aw_hs) & (w_done | w_hs))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    if (step == 4'd8) begin
                        state_nxt = DONE;
                    end else if (step == 4'd7) begin
                        state_nxt = DRAIN;
                    end else if (bad) begin
                        state_nxt = WR_ISSUE;
                        step_nxt  = 4'd7;
                        issue     = 1'b1;
                    end else if (step == 4'd6) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = WR_ISSUE;
                        step_nxt  = step + 4'd1;
                        issue     = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort || last_run) begin
                    state_nxt = WR_ISSUE;
                    step_nxt  = 4'd7;
                    issue     = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = WR_ISSUE;
                    step_nxt  = 4'd8;
                    issue     = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                step_nxt  = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = 4'd0;
            end
        endcase
    end

    // Step, latched test inputs, sticky error and the RUN/DRAIN counter.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            step  <= 4'd0;
            dur_q <= 32'd0;
            ifg_q <= 32'd0;
            fs_q  <= 32'd0;
            error <= 1'b0;
            cnt   <= 32'd0;
        end else begin
            step <= step_nxt;
            if (state == IDLE && start) begin
                dur_q <= duration;
                ifg_q <= ifg;
                fs_q  <= frame_size;
                error <= 1'b0;
            end
            if (state == WR_RESP && m_axi_bvalid && bad)
                error <= 1'b1;
            if (state_nxt == state && (state == RUN || state == DRAIN))
                cnt <= cnt + 32'd1;
            else
                cnt <= 32'd0;
        end
    end

    // AW and W channels each drop their valid after their own handshake.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else if (issue) begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            if (aw_hs) begin
                m_axi_awvalid <= 1'b0;
                aw_done       <= 1'b1;
            end
            if (w_hs) begin
                m_axi_wvalid <= 1'b0;
                w_done       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_test_sequencer.sv
// Directed bench for traffic_test_sequencer with a responsive AXI-Lite
// slave that logs every handshake and flags valid/payload instability.
module tb_traffic_test_sequencer;

    localparam logic [31:0] GEN = 32'hA0170000;
    localparam logic [31:0] ANA = 32'hA0180000;
    localparam logic [31:0] MG  = 32'hA0100000;
    localparam logic [31:0] MA  = 32'hA0150000;
    localparam int          DR  = 16;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] duration = 32'd0;
    logic [31:0] ifg = 32'd0;
    logic [31:0] frame_size = 32'd0;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb, step;
    logic        awvalid, wvalid, bready, busy, done, error;
    logic        awready = 1'b0;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    traffic_test_sequencer #(.DRAIN_CYCLES(DR)) dut (
        .aclk(aclk), .arstn(arstn), .start(start), .abort(abort),
        .duration(duration), .ifg(ifg), .frame_size(frame_size),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .busy(busy), .done(done), .error(error), .step(step)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    int w_delay = 0;
    int b_delay = 0;
    bit err_on = 1'b0;

    int cyc = 0, aw_cyc = 0, b_wait = 0, viol = 0, done_cnt = 0;
    bit aw_got, w_got, b_drop, pa_v, pa_f, pw_v, pw_f;
    logic [31:0] pa_addr, pw_data, last_addr;
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    int awc_q[$];
    int wc_q[$];
    int bc_q[$];

    // Slave + monitor: values at a negedge are what the next posedge sees.
    always @(negedge aclk) begin
        cyc++;
        if (!arstn) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_got = 0; w_got = 0; b_drop = 0; b_wait = 0;
            pa_v = 0; pa_f = 0; pw_v = 0; pw_f = 0;
        end else begin
            awready = 1'b1;
            if (b_drop) begin
                bvalid = 1'b0; bresp = 2'b00; b_drop = 0;
            end
            if (b_wait > 0) begin
                b_wait--;
                if (b_wait == 0) begin
                    bvalid = 1'b1;
                    bresp = (err_on && last_addr == GEN + 32'h14) ? 2'b10 : 2'b00;
                    aw_got = 0; w_got = 0;
                end
            end
            wready = (w_delay == 0) ? 1'b1 :
                     (aw_got && !w_got && (cyc - aw_cyc >= w_delay));
            if (pa_v && !pa_f && (!awvalid || awaddr != pa_addr)) viol++;
            if (pa_f && awvalid) viol++;
            if (pw_v && !pw_f && (!wvalid || wdata != pw_data)) viol++;
            if (pw_f && wvalid) viol++;
            pa_v = awvalid; pa_f = awvalid && awready; pa_addr = awaddr;
            pw_v = wvalid; pw_f = wvalid && wready; pw_data = wdata;
            if (pa_f) begin
                aw_q.push_back(awaddr); awc_q.push_back(cyc);
                aw_got = 1; aw_cyc = cyc; last_addr = awaddr;
            end
            if (pw_f) begin
                w_q.push_back(wdata); wc_q.push_back(cyc); w_got = 1;
            end
            if (bvalid && bready) begin
                bc_q.push_back(cyc); b_drop = 1;
            end
            if (aw_got && w_got && b_wait == 0 && !bvalid)
                b_wait = b_delay + 1;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ea(input int s);
        case (s)
            1: return MG + 32'h08;
            2: return MA + 32'h08;
            3: return GEN + 32'h14;
            4: return GEN + 32'h44;
            5: return ANA + 32'h10;
            6: return GEN + 32'h10;
            7: return GEN + 32'h10;
            8: return ANA + 32'h10;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ed(input int s, input logic [31:0] i,
                                       input logic [31:0] f);
        case (s)
            1: return 32'd3;
            3: return i;
            4: return f;
            5: return 32'd1;
            6: return 32'd3;
            8: return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk_wr(input string t, input int a0, input int w0,
                          input int k, input int s,
                          input logic [31:0] i, input logic [31:0] f);
        check($sformatf("%s_addr%0d", t, k), aw_q[a0+k], ea(s));
        check($sformatf("%s_data%0d", t, k), w_q[w0+k], ed(s, i, f));
    endtask

    task automatic pulse_start(input logic [31:0] d, input logic [31:0] i,
                               input logic [31:0] f);
        duration = d; ifg = i; frame_size = f; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int base;
        base = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge aclk); #1;
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int a0, w0, b0, d0;
        int s4[5] = '{1, 2, 3, 7, 8};

        repeat (3) @(posedge aclk); #1;
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_step", 32'(step), 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);
        check("awprot", 32'(awprot), 0);
        check("wstrb", 32'(wstrb), 32'hF);
        arstn = 1'b1;
        @(posedge aclk); #1;

        // Nominal run; inputs changed after start must not leak in.
        a0 = aw_q.size(); w0 = w_q.size(); b0 = bc_q.size(); d0 = done_cnt;
        pulse_start(100, 12, 50);
        check("t1_awvalid0", 32'(awvalid), 1);
        check("t1_wvalid0", 32'(wvalid), 1);
        check("t1_step0", 32'(step), 1);
        check("t1_busy0", 32'(busy), 1);
        check("t1_awaddr0", awaddr, MG + 32'h08);
        ifg = 99; frame_size = 77; duration = 5;
        wait_done(3000, ok);
        check("t1_finished", 32'(ok), 1);
        check("t1_naw", aw_q.size() - a0, 8);
        check("t1_nw", w_q.size() - w0, 8);
        check("t1_nb", bc_q.size() - b0, 8);
        if (aw_q.size() - a0 == 8 && w_q.size() - w0 == 8)
            for (int k = 0; k < 8; k++) chk_wr("t1", a0, w0, k, k + 1, 12, 50);
        if (bc_q.size() - b0 == 8 && aw_q.size() - a0 == 8) begin
            check("t1_run_gap", awc_q[a0+6] - bc_q[b0+5], 101);
            check("t1_drain_gap", awc_q[a0+7] - bc_q[b0+6], DR + 1);
        end
        check("t1_error", 32'(error), 0);
        check("t1_step_end", 32'(step), 0);
        check("t1_busy_end", 32'(busy), 0);
        repeat (2) @(posedge aclk); #1;
        check("t1_done_pulses", done_cnt - d0, 1);

        // Backpressure: W accepted 5 cycles after AW, B 3 idle cycles later.
        w_delay = 5; b_delay = 3;
        a0 = aw_q.size(); w0 = w_q.size(); b0 = bc_q.size();
        pulse_start(4, 7, 64);
        wait_done(3000, ok);
        check("t2_finished", 32'(ok), 1);
        check("t2_naw", aw_q.size() - a0, 8);
        check("t2_nw", w_q.size() - w0, 8);
        check("t2_nb", bc_q.size() - b0, 8);
        if (aw_q.size() - a0 == 8 && w_q.size() - w0 == 8) begin
            for (int k = 0; k < 8; k++) chk_wr("t2", a0, w0, k, k + 1, 7, 64);
            check("t2_w_lag", wc_q[w0] - awc_q[a0], 5);
            if (bc_q.size() - b0 == 8)
                check("t2_b_lag", bc_q[b0] - wc_q[w0], 4);
        end
        check("t2_viol", viol, 0);
        w_delay = 0; b_delay = 0;

        // Abort at RUN cycle 10 of a 1000-cycle run.
        a0 = aw_q.size(); w0 = w_q.size(); b0 = bc_q.size();
        pulse_start(1000, 12, 50);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge aclk); #1;
            if (bc_q.size() - b0 == 6) begin
                ok = 1'b1;
                break;
            end
        end
        check("t3_reached_run", 32'(ok), 1);
        repeat (10) @(posedge aclk); #1;
        abort = 1'b1;
        @(posedge aclk); #1;
        abort = 1'b0;
        wait_done(3000, ok);
        check("t3_finished", 32'(ok), 1);
        check("t3_naw", aw_q.size() - a0, 8);
        if (aw_q.size() - a0 == 8 && bc_q.size() - b0 == 8)
            check("t3_run_gap", awc_q[a0+6] - bc_q[b0+5], 12);
        check("t3_error", 32'(error), 0);

        // SLVERR on write 3: skip to generator stop, error sticks.
        err_on = 1'b1;
        a0 = aw_q.size(); w0 = w_q.size();
        pulse_start(50, 12, 50);
        wait_done(3000, ok);
        check("t4_finished", 32'(ok), 1);
        check("t4_naw", aw_q.size() - a0, 5);
        if (aw_q.size() - a0 == 5 && w_q.size() - w0 == 5)
            for (int k = 0; k < 5; k++) chk_wr("t4", a0, w0, k, s4[k], 12, 50);
        check("t4_error", 32'(error), 1);
        repeat (3) @(posedge aclk); #1;
        check("t4_error_held", 32'(error), 1);
        err_on = 1'b0;

        // duration=0 gives a one-cycle RUN; the new start clears error.
        a0 = aw_q.size(); b0 = bc_q.size();
        pulse_start(0, 12, 50);
        check("t5_error_clr", 32'(error), 0);
        wait_done(3000, ok);
        check("t5_finished", 32'(ok), 1);
        check("t5_naw", aw_q.size() - a0, 8);
        if (aw_q.size() - a0 == 8 && bc_q.size() - b0 == 8)
            check("t5_run_gap", awc_q[a0+6] - bc_q[b0+5], 2);

        // Reset while write 4 has awvalid high.
        pulse_start(50, 12, 50);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge aclk); #1;
            if (awvalid && step == 4'd4) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_in_write4", 32'(ok), 1);
        #1 arstn = 1'b0;
        #1;
        check("t6_awvalid", 32'(awvalid), 0);
        check("t6_wvalid", 32'(wvalid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_step", 32'(step), 0);
        check("t6_awaddr", awaddr, 0);
        check("t6_wdata", wdata, 0);
        repeat (2) @(posedge aclk); #1;
        arstn = 1'b1;
        @(posedge aclk); #1;
        check("t6_idle", 32'(busy), 0);
        a0 = aw_q.size();
        pulse_start(20, 3, 4);
        check("t6_restart_step", 32'(step), 1);
        check("t6_restart_addr", awaddr, MG + 32'h08);
        wait_done(3000, ok);
        check("t6_finished", 32'(ok), 1);
        check("t6_naw", aw_q.size() - a0, 8);
        check("viol_total", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
